// File: rtl/cpu_pkg.sv
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared constants and control types for the single-cycle CPU.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int PC_W   = 10;
    localparam int NREG   = 16;

    localparam logic [3:0] OP_J   = 4'b0000;
    localparam logic [3:0] OP_JZ  = 4'b0001;
    localparam logic [3:0] OP_JNZ = 4'b0010;
    localparam logic [3:0] OP_LI  = 4'b0011;

    localparam logic [2:0] ALU_PASS_A = 3'b000;
    localparam logic [2:0] ALU_NOT_A  = 3'b001;
    localparam logic [2:0] ALU_ADD    = 3'b010;
    localparam logic [2:0] ALU_SUB    = 3'b011;
    localparam logic [2:0] ALU_AND    = 3'b100;
    localparam logic [2:0] ALU_OR     = 3'b101;
    localparam logic [2:0] ALU_NEG_A  = 3'b110;
    localparam logic [2:0] ALU_NEG_B  = 3'b111;

    typedef enum logic [1:0] {
        PC_INC = 2'd0,
        PC_JMP = 2'd1,
        PC_JZ  = 2'd2,
        PC_JNZ = 2'd3
    } pc_sel_e;

    typedef struct packed {
        logic    reg_we;
        logic    sel_li;
        logic    z_we;
        pc_sel_e pc_sel;
    } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/cd.sv
// ============================================================================
//  Module      : cd
//  Description : Datapath: PC, program ROM, register file, ALU and zero flag.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module cd #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int PC_W   = cpu_pkg::PC_W,
    parameter int NREG   = cpu_pkg::NREG
) (
    input  logic           clk,
    input  logic           rst,
    input  cpu_pkg::ctrl_t i_ctrl,
    output logic [5:0]     o_ins_hi
);

    import cpu_pkg::*;

    // Program image is preloaded into this array by the environment.
    logic [15:0]       rom [0:(2**PC_W)-1];

    logic [PC_W-1:0]   r_pc;
    logic              r_z;

    logic [15:0]       w_ins;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic [DATA_W-1:0] w_alu;
    logic [DATA_W-1:0] w_imm;
    logic [DATA_W-1:0] w_wd;
    logic [PC_W-1:0]   w_pc_inc;
    logic [PC_W-1:0]   w_pc_next;

    assign w_ins    = rom[r_pc];
    assign o_ins_hi = w_ins[15:10];

    regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) banco_registros (
        .clk  (clk),
        .rst  (rst),
        .i_ra (w_ins[11:8]),
        .i_rb (w_ins[7:4]),
        .i_we (i_ctrl.reg_we),
        .i_wa (w_ins[3:0]),
        .i_wd (w_wd),
        .o_da (w_a),
        .o_db (w_b)
    );

    always_comb begin
        w_alu = w_a;
        case (w_ins[14:12])
            ALU_PASS_A: w_alu = w_a;
            ALU_NOT_A:  w_alu = ~w_a;
            ALU_ADD:    w_alu = w_a + w_b;
            ALU_SUB:    w_alu = w_a - w_b;
            ALU_AND:    w_alu = w_a & w_b;
            ALU_OR:     w_alu = w_a | w_b;
            ALU_NEG_A:  w_alu = '0 - w_a;
            ALU_NEG_B:  w_alu = '0 - w_b;
            default:    w_alu = w_a;
        endcase
    end

    assign w_imm    = {{(DATA_W-8){w_ins[11]}}, w_ins[11:4]};
    assign w_wd     = i_ctrl.sel_li ? w_imm : w_alu;
    assign w_pc_inc = r_pc + {{(PC_W-1){1'b0}}, 1'b1};

    always_comb begin
        w_pc_next = w_pc_inc;
        case (i_ctrl.pc_sel)
            PC_JMP:  w_pc_next = w_ins[PC_W-1:0];
            PC_JZ:   w_pc_next = r_z ? w_ins[PC_W-1:0] : w_pc_inc;
            PC_JNZ:  w_pc_next = r_z ? w_pc_inc : w_ins[PC_W-1:0];
            default: w_pc_next = w_pc_inc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= '0;
            r_z  <= 1'b0;
        end else begin
            r_pc <= w_pc_next;
            if (i_ctrl.z_we) begin
                r_z <= (w_alu == '0);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/regfile.sv
// ============================================================================
//  Module      : regfile
//  Description : 2-read / 1-write register file, register 0 hardwired to zero.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module regfile #(
    parameter int DATA_W = 16,
    parameter int NREG   = 16,
    parameter int REG_AW = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] i_ra,
    input  logic [REG_AW-1:0] i_rb,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_wa,
    input  logic [DATA_W-1:0] i_wd,
    output logic [DATA_W-1:0] o_da,
    output logic [DATA_W-1:0] o_db
);

    logic [DATA_W-1:0] regb [0:NREG-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regb[i] <= '0;
            end
        end else if (i_we && (i_wa != '0)) begin
            regb[i_wa] <= i_wd;
        end
    end

    assign o_da = (i_ra == '0) ? '0 : regb[i_ra];
    assign o_db = (i_rb == '0) ? '0 : regb[i_rb];

endmodule

`default_nettype wire

// File: rtl/uc.sv
// ============================================================================
//  Module      : uc
//  Description : Control unit, decodes the instruction top bits into controls.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module uc
    import cpu_pkg::*;
(
    input  logic [5:0] i_ins_hi,
    output ctrl_t      o_ctrl
);

    logic [3:0] w_opcode;
    logic       w_jmp_ok;

    assign w_opcode = i_ins_hi[5:2];
    // Jumps with non-zero bits [11:10] decode as NOP.
    assign w_jmp_ok = (i_ins_hi[1:0] == 2'b00);

    always_comb begin
        o_ctrl.reg_we = 1'b0;
        o_ctrl.sel_li = 1'b0;
        o_ctrl.z_we   = 1'b0;
        o_ctrl.pc_sel = PC_INC;
        if (w_opcode[3]) begin
            o_ctrl.reg_we = 1'b1;
            o_ctrl.z_we   = 1'b1;
        end else begin
            case (w_opcode)
                OP_LI: begin
                    o_ctrl.reg_we = 1'b1;
                    o_ctrl.sel_li = 1'b1;
                end
                OP_J:    if (w_jmp_ok) o_ctrl.pc_sel = PC_JMP;
                OP_JZ:   if (w_jmp_ok) o_ctrl.pc_sel = PC_JZ;
                OP_JNZ:  if (w_jmp_ok) o_ctrl.pc_sel = PC_JNZ;
                default: o_ctrl.pc_sel = PC_INC;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/cpu_single_cycle.sv
// ============================================================================
//  Module      : cpu_single_cycle
//  Description : Single-cycle 16-bit CPU top: control unit plus datapath.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module cpu_single_cycle #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int PC_W   = cpu_pkg::PC_W,
    parameter int NREG   = cpu_pkg::NREG
) (
    input  logic clk,
    input  logic reset
);

    import cpu_pkg::*;

    ctrl_t      w_ctrl;
    logic [5:0] w_ins_hi;

    uc unidad_control (
        .i_ins_hi (w_ins_hi),
        .o_ctrl   (w_ctrl)
    );

    cd #(
        .DATA_W (DATA_W),
        .PC_W   (PC_W),
        .NREG   (NREG)
    ) camino_datos (
        .clk      (clk),
        .rst      (reset),
        .i_ctrl   (w_ctrl),
        .o_ins_hi (w_ins_hi)
    );

endmodule

`default_nettype wire

// File: tb/tb_cpu_single_cycle.sv
// ============================================================================
//  Module      : tb_cpu_single_cycle
//  Description : Directed self-checking bench for the single-cycle CPU.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_cpu_single_cycle;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int checks = 0;
    int errors = 0;

    localparam int SEL_PC = 16;
    localparam int SEL_Z  = 17;
    localparam logic [15:0] NOP = 16'h4000;

    typedef struct {
        string       tag;
        int          sel;
        logic [15:0] exp;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    cpu_single_cycle dut (
        .clk   (clk),
        .reset (reset)
    );

    function automatic logic [15:0] f_alu(input logic [2:0] op, input logic [3:0] s,
                                          input logic [3:0] t, input logic [3:0] d);
        return {1'b1, op, s, t, d};
    endfunction

    function automatic logic [15:0] f_li(input logic [7:0] imm, input logic [3:0] d);
        return {4'b0011, imm, d};
    endfunction

    function automatic logic [15:0] f_jmp(input logic [3:0] op, input logic [9:0] a);
        return {op, 2'b00, a};
    endfunction

    function automatic logic [15:0] observe(input int sel);
        if (sel == SEL_PC) return {6'd0, dut.camino_datos.r_pc};
        if (sel == SEL_Z)  return {15'd0, dut.camino_datos.r_z};
        return dut.camino_datos.banco_registros.regb[sel];
    endfunction

    task automatic put(input int a, input logic [15:0] w);
        dut.camino_datos.rom[a] = w;
    endtask

    task automatic fill_nop();
        for (int i = 0; i < 1024; i++) dut.camino_datos.rom[i] = NOP;
    endtask

    task automatic expect_val(input string tag, input int sel, input logic [15:0] v);
        sb.push_back('{tag, sel, v});
    endtask

    task automatic expect_reset_state(input string pfx);
        for (int r = 0; r < 16; r++) expect_val($sformatf("%s_r%0d", pfx, r), r, 16'h0000);
        expect_val({pfx, "_pc"}, SEL_PC, 16'h0000);
        expect_val({pfx, "_z"}, SEL_Z, 16'h0000);
    endtask

    task automatic drain();
        exp_t e;
        logic [15:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Program A: LI, all ALU ops, R0 write, Z behaviour.
        reset = 1'b1;
        fill_nop();
        put(0,  f_li(8'd5, 4'd1));
        put(1,  f_li(8'hFD, 4'd2));
        put(2,  f_alu(3'b010, 4'd1, 4'd2, 4'd3));
        put(3,  f_alu(3'b011, 4'd1, 4'd2, 4'd4));
        put(4,  f_alu(3'b100, 4'd1, 4'd2, 4'd5));
        put(5,  f_alu(3'b101, 4'd1, 4'd2, 4'd6));
        put(6,  f_alu(3'b110, 4'd1, 4'd2, 4'd7));
        put(7,  f_alu(3'b111, 4'd1, 4'd2, 4'd8));
        put(8,  f_alu(3'b001, 4'd1, 4'd0, 4'd9));
        put(9,  f_alu(3'b000, 4'd1, 4'd0, 4'd10));
        put(10, f_alu(3'b010, 4'd1, 4'd1, 4'd0));
        put(11, f_alu(3'b011, 4'd1, 4'd1, 4'd11));
        put(12, f_li(8'h7F, 4'd13));
        put(13, f_alu(3'b010, 4'd1, 4'd1, 4'd1));
        put(14, f_jmp(4'b0000, 10'd14));
        step(2);
        expect_reset_state("rst");
        drain();

        reset = 1'b0;
        step(2);
        expect_val("li_r1", 1, 16'h0005);
        expect_val("li_r2_sext", 2, 16'hFFFD);
        expect_val("li_pc", SEL_PC, 16'd2);
        drain();

        step(9);
        expect_val("alu_add", 3, 16'h0002);
        expect_val("alu_sub", 4, 16'h0008);
        expect_val("alu_and", 5, 16'h0005);
        expect_val("alu_or", 6, 16'hFFFD);
        expect_val("alu_nega", 7, 16'hFFFB);
        expect_val("alu_negb", 8, 16'h0003);
        expect_val("alu_not", 9, 16'hFFFA);
        expect_val("alu_pass", 10, 16'h0005);
        expect_val("r0_hardwired", 0, 16'h0000);
        expect_val("z_after_nonzero", SEL_Z, 16'h0000);
        expect_val("alu_pc", SEL_PC, 16'd11);
        drain();

        step(1);
        expect_val("sub_zero", 11, 16'h0000);
        expect_val("z_set", SEL_Z, 16'h0001);
        drain();
        step(1);
        expect_val("li_pos", 13, 16'h007F);
        expect_val("z_kept_by_li", SEL_Z, 16'h0001);
        drain();
        step(1);
        expect_val("same_src_dst", 1, 16'h000A);
        expect_val("z_clear", SEL_Z, 16'h0000);
        drain();
        step(3);
        expect_val("self_jump_pc", SEL_PC, 16'd14);
        drain();

        // Reset asserted mid-run on program A.
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(6);
        expect_val("mid_r6", 6, 16'hFFFD);
        expect_val("mid_pc", SEL_PC, 16'd6);
        drain();
        reset = 1'b1;
        step(1);
        expect_reset_state("midrst");
        drain();
        reset = 1'b0;
        step(2);
        expect_val("restart_r1", 1, 16'h0005);
        expect_val("restart_r2", 2, 16'hFFFD);
        expect_val("restart_pc", SEL_PC, 16'd2);
        drain();

        // Program B: countdown loop with JNZ, then JZ taken.
        reset = 1'b1;
        fill_nop();
        put(0, f_li(8'd3, 4'd1));
        put(1, f_li(8'd1, 4'd2));
        put(2, f_alu(3'b011, 4'd1, 4'd2, 4'd1));
        put(3, f_jmp(4'b0010, 10'd2));
        put(4, f_jmp(4'b0001, 10'd6));
        put(5, f_li(8'd7, 4'd3));
        put(6, f_li(8'd9, 4'd4));
        put(7, f_jmp(4'b0000, 10'd7));
        step(1);
        reset = 1'b0;
        step(4);
        expect_val("loop1_r1", 1, 16'h0002);
        expect_val("jnz_taken_pc", SEL_PC, 16'd2);
        drain();
        step(4);
        expect_val("loop_end_r1", 1, 16'h0000);
        expect_val("loop_end_z", SEL_Z, 16'h0001);
        expect_val("jnz_fall_pc", SEL_PC, 16'd4);
        drain();
        step(1);
        expect_val("jz_taken_pc", SEL_PC, 16'd6);
        drain();
        step(1);
        expect_val("jz_skip_r3", 3, 16'h0000);
        expect_val("jz_target_r4", 4, 16'h0009);
        drain();

        // Program C: ignored jump, JZ not taken, J 1023 and PC wrap.
        reset = 1'b1;
        fill_nop();
        put(0, {4'b0000, 2'b01, 10'd5});
        put(1, f_jmp(4'b0001, 10'd5));
        put(2, f_li(8'd1, 4'd1));
        put(3, f_jmp(4'b0000, 10'd1023));
        step(1);
        reset = 1'b0;
        step(1);
        expect_val("jmp_bits_nop_pc", SEL_PC, 16'd1);
        drain();
        step(1);
        expect_val("jz_not_taken_pc", SEL_PC, 16'd2);
        drain();
        step(2);
        expect_val("j1023_pc", SEL_PC, 16'd1023);
        expect_val("wrap_r1", 1, 16'h0001);
        drain();
        step(1);
        expect_val("wrap_pc", SEL_PC, 16'd0);
        drain();

        step(120);
        for (int r = 0; r < 16; r++) begin
            $display("R%0d = %0d", r, $signed(dut.camino_datos.banco_registros.regb[r]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
